// File: rtl/pose_pkg.sv
// Shared types and constants for the pose score accumulator.
package pose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int HRES_DEF       = 320;
    localparam int VRES_DEF       = 180;
    localparam int LATENCY_DEF    = 3;
    localparam int CLAMP_DEF      = 32;
    localparam int AVG_THRESH_DEF = 8;

    // Distance the scorer reports when no reference pixel exists.
    function automatic int scorer_inf(input int hres, input int vres);
        return hres + vres;
    endfunction

    localparam int INF_DEF    = scorer_inf(HRES_DEF, VRES_DEF);
    localparam int HWIDTH_DEF = $clog2(HRES_DEF);
    localparam int VWIDTH_DEF = $clog2(VRES_DEF);
    localparam int DWIDTH_DEF = $clog2(INF_DEF + 1);
    localparam int CWIDTH_DEF = $clog2(HRES_DEF * VRES_DEF + 1);
    localparam int SWIDTH_DEF = $clog2(HRES_DEF * VRES_DEF * CLAMP_DEF + 1);

endpackage

// File: rtl/issue_delay_line.sv
// Issue record: LATENCY-deep shift register of {valid, h, v}, one shift per cycle.
module issue_delay_line #(
    parameter int LATENCY = 3,
    parameter int HWIDTH  = 9,
    parameter int VWIDTH  = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              push_valid_in,
    input  logic [HWIDTH-1:0] push_hcount_in,
    input  logic [VWIDTH-1:0] push_vcount_in,
    output logic              pop_valid_out,
    output logic [HWIDTH-1:0] pop_hcount_out,
    output logic [VWIDTH-1:0] pop_vcount_out
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [HWIDTH-1:0]  h_q [LATENCY];
    logic [HWIDTH-1:0]  h_d [LATENCY];
    logic [VWIDTH-1:0]  v_q [LATENCY];
    logic [VWIDTH-1:0]  v_d [LATENCY];

    // Shift every cycle; stage 0 takes the new record.
    always_comb begin
        valid_d[0] = push_valid_in;
        h_d[0]     = push_hcount_in;
        v_d[0]     = push_vcount_in;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            h_d[i]     = h_q[i-1];
            v_d[i]     = v_q[i-1];
        end
    end

    // Stage registers, cleared on reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            h_q     <= '{default: '0};
            v_q     <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign pop_valid_out  = valid_q[LATENCY-1];
    assign pop_hcount_out = h_q[LATENCY-1];
    assign pop_vcount_out = v_q[LATENCY-1];

endmodule

// File: rtl/pose_score_accumulator.sv
// Streams the skeleton mask, issues one distance query per set pixel, checks the
// scorer's fixed-latency responses against the issue record and accumulates a
// per-frame score of clamped distances.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start_in; results from the last frame held
// ST_RUN   | accepting mask beats while the scorer is in query mode
// ST_DRAIN | no new issues; waits for the last record to retire
// ST_DONE  | one cycle: score_valid_out pulses, match decision latched
module pose_score_accumulator
    import pose_pkg::*;
#(
    parameter int  HRES       = HRES_DEF,
    parameter int  VRES       = VRES_DEF,
    parameter int  LATENCY    = LATENCY_DEF,
    parameter int  CLAMP      = CLAMP_DEF,
    parameter int  AVG_THRESH = AVG_THRESH_DEF,
    localparam int HWIDTH     = $clog2(HRES),
    localparam int VWIDTH     = $clog2(VRES),
    localparam int DWIDTH     = $clog2(scorer_inf(HRES, VRES) + 1),
    localparam int CWIDTH     = $clog2(HRES * VRES + 1),
    localparam int SWIDTH     = $clog2(HRES * VRES * CLAMP + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              scorer_ready_in,
    input  logic [HWIDTH-1:0] mask_hcount_in,
    input  logic [VWIDTH-1:0] mask_vcount_in,
    input  logic              mask_pixel_in,
    input  logic              mask_valid_in,
    output logic              mask_ready_out,
    output logic [HWIDTH-1:0] query_hcount_out,
    output logic [VWIDTH-1:0] query_vcount_out,
    output logic              query_valid_out,
    input  logic [HWIDTH-1:0] resp_hcount_in,
    input  logic [VWIDTH-1:0] resp_vcount_in,
    input  logic [DWIDTH-1:0] resp_distance_in,
    input  logic              resp_valid_in,
    output logic [SWIDTH-1:0] score_sum_out,
    output logic [CWIDTH-1:0] score_count_out,
    output logic              score_valid_out,
    output logic              match_out,
    output logic              error_out
);

    // The drain timer spans the whole delay line, so the last accepted beat
    // (issued or not) retires in the final DRAIN cycle and DONE follows.
    localparam int TWIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e              state_q, state_d;
    logic [TWIDTH-1:0]   drain_q, drain_d;
    logic [SWIDTH-1:0]   sum_q, sum_d;
    logic [CWIDTH-1:0]   count_q, count_d;
    logic                error_q, error_d;
    logic                match_q, match_d;
    logic [HWIDTH-1:0]   qh_q, qh_d;
    logic [VWIDTH-1:0]   qv_q, qv_d;

    logic                accept, issue, last_beat, start_go;
    logic                dl_valid;
    logic [HWIDTH-1:0]   dl_h;
    logic [VWIDTH-1:0]   dl_v;
    logic                entry_ok, entry_bad, match_now;
    logic [SWIDTH-1:0]   dist_clamped, thresh;

    // Beat handshake and frame-boundary decode.
    always_comb begin
        accept    = (state_q == ST_RUN) && scorer_ready_in && mask_valid_in;
        issue     = accept && mask_pixel_in;
        last_beat = accept && (mask_hcount_in == HWIDTH'(HRES - 1))
                           && (mask_vcount_in == VWIDTH'(VRES - 1));
        start_go  = (state_q == ST_IDLE) && start_in;
    end

    issue_delay_line #(
        .LATENCY (LATENCY),
        .HWIDTH  (HWIDTH),
        .VWIDTH  (VWIDTH)
    ) u_issue_delay_line (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .push_valid_in  (issue),
        .push_hcount_in (issue ? mask_hcount_in : '0),
        .push_vcount_in (issue ? mask_vcount_in : '0),
        .pop_valid_out  (dl_valid),
        .pop_hcount_out (dl_h),
        .pop_vcount_out (dl_v)
    );

    // State and drain timer registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic and drain down-counter.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE:  if (start_in) state_d = ST_RUN;
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                    drain_d = TWIDTH'(LATENCY - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - TWIDTH'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; query coords hold their last issued value between issues.
    always_comb begin
        mask_ready_out   = (state_q == ST_RUN) && scorer_ready_in;
        query_valid_out  = issue;
        query_hcount_out = issue ? mask_hcount_in : qh_q;
        query_vcount_out = issue ? mask_vcount_in : qv_q;
        score_valid_out  = (state_q == ST_DONE);
        match_out        = (state_q == ST_DONE) ? match_now : match_q;
        score_sum_out    = sum_q;
        score_count_out  = count_q;
        error_out        = error_q;
    end

    // Response alignment against the retiring issue record and match decision.
    always_comb begin
        entry_ok  = dl_valid && resp_valid_in
                    && (resp_hcount_in == dl_h) && (resp_vcount_in == dl_v);
        entry_bad = dl_valid && !entry_ok;
        if (SWIDTH'(resp_distance_in) > SWIDTH'(CLAMP)) dist_clamped = SWIDTH'(CLAMP);
        else                                            dist_clamped = SWIDTH'(resp_distance_in);
        thresh    = SWIDTH'(count_q) * SWIDTH'(AVG_THRESH);
        match_now = (count_q != '0) && (sum_q <= thresh);
    end

    // Accumulator, sticky error, match latch and held query coords.
    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        error_d = error_q;
        match_d = match_q;
        qh_d    = qh_q;
        qv_d    = qv_q;
        if (issue) begin
            qh_d = mask_hcount_in;
            qv_d = mask_vcount_in;
        end
        if (start_go) begin
            sum_d   = '0;
            count_d = '0;
            error_d = 1'b0;
            match_d = 1'b0;
        end else begin
            if (entry_ok) begin
                sum_d   = sum_q + dist_clamped;
                count_d = count_q + CWIDTH'(1);
            end
            if (entry_bad) error_d = 1'b1;
            if (state_q == ST_DONE) match_d = match_now;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sum_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            match_q <= 1'b0;
            qh_q    <= '0;
            qv_q    <= '0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
            error_q <= error_d;
            match_q <= match_d;
            qh_q    <= qh_d;
            qv_q    <= qv_d;
        end
    end

endmodule
